// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared states, default width and counter sizing for the sequential multiplier
package seq_mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    function automatic int ctr_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_step.sv
// seq_mult_step: one shift-add (or final signed subtract) step of the multiplier
module seq_mult_step #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH:0] i_acc,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic             i_bit,
    input  logic             i_sgn,
    input  logic             i_last,
    output logic [2*WIDTH:0] o_acc
);

    logic [WIDTH:0]   w_ext;
    logic [WIDTH:0]   w_hi;
    logic [2*WIDTH:0] w_sum;
    logic [2*WIDTH:0] w_asr;

    // The upper half is WIDTH+1 bits so neither the unsigned carry nor the
    // signed -2^(W-1) * -2^(W-1) corner can overflow before the shift.
    assign w_ext = {i_sgn & i_mcand[WIDTH-1], i_mcand};
    assign w_hi  = !i_bit ? i_acc[2*WIDTH:WIDTH] :
                   (i_sgn && i_last) ? i_acc[2*WIDTH:WIDTH] - w_ext :
                   i_acc[2*WIDTH:WIDTH] + w_ext;
    assign w_sum = {w_hi, i_acc[WIDTH-1:0]};
    assign w_asr = $signed(w_sum) >>> 1;
    assign o_acc = i_sgn ? w_asr : w_sum >> 1;

endmodule

// File: rtl/seq_mult_hs.sv
// seq_mult_hs: valid/ready handshaked sequential multiplier, one multiplier bit per cycle
module seq_mult_hs
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CTR_W = ctr_width(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    state_t             r_state;
    state_t             w_next;
    logic [CTR_W-1:0]   r_ctr;
    logic [2*WIDTH:0]   r_acc;
    logic [2*WIDTH:0]   w_acc_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sgn;
    logic [2*WIDTH-1:0] r_p;
    logic               w_accept;
    logic               w_last;

    assign w_accept = in_valid && in_ready;
    assign w_last   = r_ctr == CTR_W'(WIDTH - 1);
    assign p        = r_p;

    seq_mult_step #(.WIDTH(WIDTH)) u_step (
        .i_acc   (r_acc),
        .i_mcand (r_b),
        .i_bit   (r_a[0]),
        .i_sgn   (r_sgn),
        .i_last  (w_last),
        .o_acc   (w_acc_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next state and handshake outputs; DONE accepts new work only when the result is taken
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                w_next   = w_accept ? ST_RUN : ST_IDLE;
            end
            ST_RUN: w_next = w_last ? ST_DONE : ST_RUN;
            ST_DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
                w_next    = !out_ready ? ST_DONE : (in_valid ? ST_RUN : ST_IDLE);
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand latch, per-step accumulate/shift, and product capture on the final step
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sgn <= 1'b0;
            r_ctr <= '0;
            r_acc <= '0;
            r_p   <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_sgn <= sgn;
            r_ctr <= '0;
            r_acc <= '0;
        end else if (r_state == ST_RUN) begin
            r_a   <= r_a >> 1;
            r_ctr <= r_ctr + CTR_W'(1);
            r_acc <= w_acc_next;
            if (w_last) r_p <= w_acc_next[2*WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_seq_mult_hs.sv
// tb_seq_mult_hs: directed and randomized checks of seq_mult_hs at widths 8, 4 and 16
module tb_seq_mult_hs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        sgn = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] p;

    logic        v4 = 1'b0;
    logic        s4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        r4;
    logic        ov4;
    logic [7:0]  p4;

    logic        v16 = 1'b0;
    logic        s16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        r16;
    logic        ov16;
    logic [31:0] p16;

    int n_checks = 0;
    int n_fail = 0;

    seq_mult_hs #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready), .p(p)
    );

    seq_mult_hs #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_ready(r4),
        .a(a4), .b(b4), .sgn(s4), .out_valid(ov4), .out_ready(1'b1), .p(p4)
    );

    seq_mult_hs #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(v16), .in_ready(r16),
        .a(a16), .b(b16), .sgn(s16), .out_valid(ov16), .out_ready(1'b1), .p(p16)
    );

    always #5 clk = ~clk;

    // Reference: exact integer product of the operands interpreted per mode, kept to 2*w bits
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x, input logic [31:0] y, input logic s);
        longint vx;
        longint vy;
        vx = longint'(x);
        vy = longint'(y);
        if (s && x[w-1]) vx -= (longint'(1) << w);
        if (s && y[w-1]) vy -= (longint'(1) << w);
        return 64'(vx * vy) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 operation; inputs are scrambled after acceptance to prove they were latched
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int lat;
        logic [15:0] exp;
        exp = 16'(ref_mul(8, 32'(x), 32'(y), s));
        check("rdy8", 64'(in_ready), 64'd1);
        a = x;
        b = y;
        sgn = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        sgn = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("lat8", 64'(lat), 64'd9);
        check("p8", 64'(p), 64'(exp));
        check("done_rdy8", 64'(in_ready), 64'(out_ready));
        if (out_ready) begin
            @(posedge clk); #1;
            check("idle8", 64'({out_valid, in_ready}), 64'd1);
            check("p8_hold", 64'(p), 64'(exp));
        end
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic s);
        int n;
        check("rdy4", 64'(r4), 64'd1);
        a4 = x;
        b4 = y;
        s4 = s;
        v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        n = 0;
        while (!ov4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("p4", 64'(p4), ref_mul(4, 32'(x), 32'(y), s));
        @(posedge clk); #1;
    endtask

    task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic s);
        int n;
        check("rdy16", 64'(r16), 64'd1);
        a16 = x;
        b16 = y;
        s16 = s;
        v16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0;
        n = 0;
        while (!ov16 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("p16", 64'(p16), ref_mul(16, 32'(x), 32'(y), s));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] oa [3];
        logic [7:0] ob [3];
        logic [15:0] oexp [3];
        int cnt;
        oa[0] = 8'd3;   ob[0] = 8'd5;
        oa[1] = 8'hFE;  ob[1] = 8'd7;
        oa[2] = 8'd0;   ob[2] = 8'hFF;
        for (int k = 0; k < 3; k++) oexp[k] = 16'(ref_mul(8, 32'(oa[k]), 32'(ob[k]), 1'b1));

        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", 64'(in_ready), 64'd1);
        check("rst_ov", 64'(out_valid), 64'd0);
        check("rst_p", 64'(p), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        op8(8'h80, 8'h80, 1'b1);
        check("m128sq", 64'(p), 64'h4000);
        op8(8'hFF, 8'hFF, 1'b0);
        check("ffu", 64'(p), 64'hFE01);
        op8(8'hFF, 8'hFF, 1'b1);
        check("ffs", 64'(p), 64'h0001);

        out_ready = 1'b0;
        op8(8'd127, 8'h80, 1'b1);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk); #1;
            check("hold_p", 64'(p), 64'hC080);
            check("hold_ov", 64'(out_valid), 64'd1);
            check("hold_rdy", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_rel", 64'({out_valid, in_ready}), 64'd1);

        a = oa[0];
        b = ob[0];
        sgn = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        a = oa[1];
        b = ob[1];
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            do begin
                @(posedge clk); #1;
                cnt++;
                if (cnt == 1 && k > 0) begin
                    if (k < 2) begin
                        a = oa[k + 1];
                        b = ob[k + 1];
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end while (!out_valid && cnt < 30);
            check("b2b_gap", 64'(cnt), (k == 0) ? 64'd8 : 64'd9);
            check("b2b_p", 64'(p), 64'(oexp[k]));
        end
        @(posedge clk); #1;
        check("b2b_idle", 64'({out_valid, in_ready}), 64'd1);

        op8(8'd5, 8'd5, 1'b0);
        a = 8'd10;
        b = 8'd20;
        sgn = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("run_busy", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rr_rdy", 64'(in_ready), 64'd1);
        check("rr_ov", 64'(out_valid), 64'd0);
        check("rr_p", 64'(p), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check("rr_quiet", 64'(out_valid), 64'd0);
        op8(8'd6, 8'd7, 1'b0);
        check("six7", 64'(p), 64'd42);

        for (int i = 0; i < 300; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));

        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    op4(4'(x), 4'(y), 1'(s));

        op16(16'h8000, 16'h8000, 1'b1);
        op16(16'hFFFF, 16'hFFFF, 1'b0);
        for (int i = 0; i < 2000; i++) op16(16'($urandom), 16'($urandom), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
